// File: rtl/clk_div_multi.sv
// Multi-channel programmable integer clock divider running from clk_100m.
// Each channel has its own divisor, enable and rising-edge strobe; sync phase-aligns all enabled channels.
module clk_div_multi #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                    clk_100m,
    input  logic                    btn_rst,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    sync,
    input  logic [NUM_CH*CNT_W-1:0] div_val,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       stb_out,
    output logic [NUM_CH*CNT_W-1:0] div_act
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] d_req;
        logic [CNT_W-1:0] d_new;
        logic [CNT_W-1:0] d_cur;
        logic [CNT_W-1:0] phase;
        logic [CNT_W-1:0] phase_inc;
        logic [CNT_W-1:0] hi_len;
        logic             clk_q;
        logic             stb_q;

        assign d_req = div_val[i*CNT_W +: CNT_W];

        // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
        always_comb begin
            d_new = d_req;
            if (d_req < TWO) begin
                d_new = TWO;
            end
        end

        assign hi_len    = d_cur >> 1;
        assign phase_inc = phase + ONE;

        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        always_ff @(posedge clk_100m or posedge btn_rst) begin
            if (btn_rst) begin
                d_cur <= DEF_DIV;
                phase <= DEF_DIV - ONE;
                clk_q <= 1'b0;
                stb_q <= 1'b0;
            end else if (!ch_en[i]) begin
                // Preloading phase to the wrap point makes the first enabled edge a rising edge.
                d_cur <= d_new;
                phase <= d_new - ONE;
                clk_q <= 1'b0;
                stb_q <= 1'b0;
            end else if (sync || (phase == d_cur - ONE)) begin
                d_cur <= d_new;
                phase <= '0;
                clk_q <= 1'b1;
                stb_q <= 1'b1;
            end else begin
                phase <= phase_inc;
                clk_q <= (phase_inc < hi_len);
                stb_q <= 1'b0;
            end
        end

        assign clk_out[i]                = clk_q;
        assign stb_out[i]                = stb_q;
        assign div_act[i*CNT_W +: CNT_W] = d_cur;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: two channels, hand-computed per-edge waveforms.
module tb_clk_div_multi;

    logic        clk_100m = 1'b0;
    logic        btn_rst;
    logic [1:0]  ch_en;
    logic        sync;
    logic [31:0] div_val;
    logic [1:0]  clk_out;
    logic [1:0]  stb_out;
    logic [31:0] div_act;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    clk_div_multi #(.NUM_CH(2), .CNT_W(16), .DEFAULT_DIV(4)) dut (
        .clk_100m (clk_100m),
        .btn_rst  (btn_rst),
        .ch_en    (ch_en),
        .sync     (sync),
        .div_val  (div_val),
        .clk_out  (clk_out),
        .stb_out  (stb_out),
        .div_act  (div_act)
    );

    always #5 clk_100m = ~clk_100m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100m);
        #1;
        edge_n++;
    endtask

    // One character per edge: '1'/'0' expected level, '-' or end of string means unchecked.
    task automatic step(input string c0, input string s0, input string c1, input string s1);
        for (int i = 0; i < c0.len(); i++) begin
            tick();
            if (c0[i] != "-")
                check($sformatf("clk0@%0d", edge_n), 64'(clk_out[0]), 64'(c0[i] == "1"));
            if (i < s0.len() && s0[i] != "-")
                check($sformatf("stb0@%0d", edge_n), 64'(stb_out[0]), 64'(s0[i] == "1"));
            if (i < c1.len() && c1[i] != "-")
                check($sformatf("clk1@%0d", edge_n), 64'(clk_out[1]), 64'(c1[i] == "1"));
            if (i < s1.len() && s1[i] != "-")
                check($sformatf("stb1@%0d", edge_n), 64'(stb_out[1]), 64'(s1[i] == "1"));
        end
    endtask

    initial begin
        btn_rst = 1'b1;
        ch_en   = 2'b11;
        sync    = 1'b0;
        div_val = {16'd4, 16'd4};
        tick();
        tick();
        check("rst_clk", 64'(clk_out), 64'd0);
        check("rst_stb", 64'(stb_out), 64'd0);
        check("rst_div", 64'(div_act), 64'h0004_0004);

        // Default divide-by-4 on both channels, edges 1..9
        @(negedge clk_100m);
        btn_rst = 1'b0;
        edge_n  = 0;
        step("110011001", "100010001", "110011001", "100010001");

        // Mid-period change to 10 on channel 0: current period of 4 completes first
        div_val[15:0] = 16'd10;
        step("100", "000", "", "");
        check("div0_hold4", 64'(div_act[15:0]), 64'd4);
        step("1", "1", "", "");
        check("div0_now10", 64'(div_act[15:0]), 64'd10);
        step("1111000001", "0000000001", "", "");

        // Odd divisor 5: 2 high / 3 low
        div_val[15:0] = 16'd5;
        step("111100000", "000000000", "", "");
        step("110001", "100001", "", "");
        check("div0_5", 64'(div_act[15:0]), 64'd5);

        // Divisor 0 clamps to 2
        div_val[15:0] = 16'd0;
        step("10001010", "00001010", "", "");
        check("div0_clamp0", 64'(div_act[15:0]), 64'd2);

        // Divisor 1 clamps to 2
        div_val[15:0] = 16'd1;
        step("1010", "1010", "", "");
        check("div0_clamp1", 64'(div_act[15:0]), 64'd2);

        // Channel 0 div 4, channel 1 div 6, then sync aligns both
        div_val = {16'd6, 16'd4};
        tick();
        tick();
        tick();
        sync = 1'b1;
        step("1", "1", "1", "1");
        sync = 1'b0;
        check("sync_div", 64'(div_act), 64'h0006_0004);
        step("100110011001", "000100010001", "110001110001", "000001000001");

        // Disable channel 1 while high, then re-enable
        step("1", "0", "1", "0");
        ch_en = 2'b01;
        step("001", "001", "000", "000");
        check("dis_div1", 64'(div_act[31:16]), 64'd6);
        ch_en = 2'b11;
        step("1001", "0001", "1110", "1000");

        // Sync while channel 1 disabled: only channel 0 restarts
        ch_en = 2'b01;
        sync  = 1'b1;
        step("1", "1", "0", "0");
        sync = 1'b0;
        step("10", "00", "00", "00");

        // Re-enable, then asynchronous reset while both outputs are high
        ch_en = 2'b11;
        step("01", "01", "11", "10");
        check("pre_rst_high", 64'(clk_out), 64'd3);
        #1;
        btn_rst = 1'b1;
        #1;
        check("async_rst_clk", 64'(clk_out), 64'd0);
        check("async_rst_stb", 64'(stb_out), 64'd0);
        check("async_rst_div", 64'(div_act), 64'h0004_0004);
        @(negedge clk_100m);
        btn_rst = 1'b0;
        step("1", "1", "1", "1");
        check("post_rst_div", 64'(div_act), 64'h0006_0004);
        step("1", "0", "1", "0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
